// File: rtl/edge_event_counter.sv
// Rising-edge window counter: syncs async i, counts rises over WINDOW-cycle windows, reports each count.
// Latency: level follows i after 2 cycles (+FILTER_LEN with EDGE_FILTER_EN); count valid 1 cycle after window end.
// Backpressure: count held until count_ready; a window closing while stalled is dropped and sets sticky overrun.
//
// Optional feature macro: EDGE_FILTER_EN (glitch filter requiring FILTER_LEN equal samples).
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i                 asynchronous input level
//   enable            1 = measure, 0 = idle (partial window discarded)
//   count_ready       consumer accepts count this cycle
//   count             rising-edge count of last closed window
//   count_valid       count/overflow valid, held until count_ready
//   overflow          counter saturated during the reported window
//   overrun           sticky: a closed window was dropped while stalled
//   level             synchronised (and filtered) level of i
module edge_event_counter #(
  parameter int COUNT_W    = 8,
  parameter int WINDOW     = 16,
  parameter int FILTER_LEN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i,
  input  logic               enable,
  input  logic               count_ready,
  output logic [COUNT_W-1:0] count,
  output logic               count_valid,
  output logic               overflow,
  output logic               overrun,
  output logic               level
);

  localparam int                 TIMER_W    = $clog2(WINDOW);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX    = '1;

  if (WINDOW < 2) begin : g_window_chk
    $error("edge_event_counter: WINDOW must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_filter_chk
    $error("edge_event_counter: FILTER_LEN must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic level_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i;
      sync2_q <= sync1_q;
    end
  end

`ifdef EDGE_FILTER_EN
  // Level flips only once the synchronised input has disagreed with it for
  // FILTER_LEN consecutive cycles; any agreeing sample restarts the run.
  localparam int                FCNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              flt_q, flt_d;

  always_comb begin
    fcnt_d = '0;
    flt_d  = flt_q;
    if (sync2_q != flt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        flt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      flt_q  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      flt_q  <= flt_d;
    end
  end

  assign level_w = flt_q;
`else
  assign level_w = sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM:  state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Window datapath
  // ---------------------------------------------------------------------------
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               wovf_q, wovf_d;
  logic               prev_q, prev_d;

  logic               run, terminal, rise, cnt_at_max;
  logic [COUNT_W-1:0] snap_cnt;
  logic               snap_ovf;

  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               ovr_q, ovr_d;

  always_comb begin
    run        = (state_q == ST_RUN) && enable;
    terminal   = run && (timer_q == TIMER_LAST);
    // prev tracks level every cycle, so the ARM cycle primes it and a level
    // already high at enable is never seen as an edge.
    rise       = (state_q == ST_RUN) && level_w && !prev_q;
    cnt_at_max = (cnt_q == CNT_MAX);
    snap_cnt   = (rise && !cnt_at_max) ? cnt_q + 1'b1 : cnt_q;
    snap_ovf   = wovf_q || (rise && cnt_at_max);

    timer_d = '0;
    cnt_d   = '0;
    wovf_d  = 1'b0;
    prev_d  = level_w;
    if (run) begin
      timer_d = terminal ? '0 : timer_q + 1'b1;
      // At the terminal cycle the running values are handed to the snapshot
      // and the window state restarts from zero.
      if (!terminal) begin
        cnt_d  = snap_cnt;
        wovf_d = snap_ovf;
      end
    end
  end

  // Output register: a transfer frees the slot; a closing window reuses it in
  // the same cycle, otherwise the snapshot is dropped and overrun is flagged.
  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    ovr_d   = ovr_q;
    if (valid_q && count_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (terminal) begin
      if (!valid_q || count_ready) begin
        valid_d = 1'b1;
        count_d = snap_cnt;
        ovf_d   = snap_ovf;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      wovf_q  <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      wovf_q  <= wovf_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign overrun     = ovr_q;
  assign level       = level_w;

endmodule

// File: tb/tb_edge_event_counter.sv
// Testbench for edge_event_counter: directed table of periodic input patterns plus
// hand-written sequences for stall/overrun, enable drop, level-high arm, reset and saturation.
module tb_edge_event_counter;

  logic       clk;
  logic       rst_n;
  logic       i, enable, count_ready;
  logic [7:0] count;
  logic       count_valid, overflow, overrun, level;

  logic       i_b, enable_b, ready_b;
  logic [3:0] count_b;
  logic       valid_b, ovf_b, ovr_b, level_b;

  edge_event_counter #(.COUNT_W(8), .WINDOW(16), .FILTER_LEN(3)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i           (i),
    .enable      (enable),
    .count_ready (count_ready),
    .count       (count),
    .count_valid (count_valid),
    .overflow    (overflow),
    .overrun     (overrun),
    .level       (level)
  );

  edge_event_counter #(.COUNT_W(4), .WINDOW(64), .FILTER_LEN(1)) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .i           (i_b),
    .enable      (enable_b),
    .count_ready (ready_b),
    .count       (count_b),
    .count_valid (valid_b),
    .overflow    (ovf_b),
    .overrun     (ovr_b),
    .level       (level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef EDGE_FILTER_EN
  localparam int P_HI  = 4;   // pattern period 8: 2 rises per 16-cycle window
  localparam int P_EXP = 2;
`else
  localparam int P_HI  = 2;   // pattern period 4: 4 rises per 16-cycle window
  localparam int P_EXP = 4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Periodic pattern generator for i, advanced once per tick
  int   pcnt    = 0;
  int   pat_per = 4;
  int   pat_hi  = 2;
  logic pat_on  = 1'b0;
  logic tog_b   = 1'b0;

  typedef struct {
    int hi;
    int lo;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pat_on) begin
      pcnt = (pcnt + 1) % pat_per;
      i    = (pcnt < pat_hi);
    end
    if (tog_b) i_b = ~i_b;
  endtask

  task automatic set_pattern(input int hi, input int lo);
    pat_per = hi + lo;
    pat_hi  = hi;
    pcnt    = 0;
    pat_on  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;

    vecs[0] = '{hi: 2, lo: 2,  exp_cnt: 4};
    vecs[1] = '{hi: 1, lo: 1,  exp_cnt: 8};
    vecs[2] = '{hi: 4, lo: 4,  exp_cnt: 2};
    vecs[3] = '{hi: 8, lo: 8,  exp_cnt: 1};
    vecs[4] = '{hi: 1, lo: 3,  exp_cnt: 4};
    vecs[5] = '{hi: 4, lo: 12, exp_cnt: 1};
`ifdef EDGE_FILTER_EN
    // Highs shorter than FILTER_LEN never reach level
    vecs[0].exp_cnt = 0;
    vecs[1].exp_cnt = 0;
    vecs[4].exp_cnt = 0;
`endif

    rst_n = 1'b0; i = 1'b0; enable = 1'b0; count_ready = 1'b1;
    i_b = 1'b0; enable_b = 1'b0; ready_b = 1'b1;

    // ---------------- reset values ----------------
    repeat (3) tick();
    check("rst_count",    count,       0);
    check("rst_valid",    count_valid, 0);
    check("rst_overflow", overflow,    0);
    check("rst_overrun",  overrun,     0);
    check("rst_level",    level,       0);
    check("rst_b_count",  count_b,     0);
    check("rst_b_valid",  valid_b,     0);
    rst_n = 1'b1;
    repeat (2) tick();

    // ---------------- table: steady periodic patterns, ready=1 ----------------
    for (int v = 0; v < 6; v++) begin
      set_pattern(vecs[v].hi, vecs[v].lo);
      enable = 1'b0; count_ready = 1'b1;
      repeat (20) tick();
      enable = 1'b1;
      nv = 0;
      for (int k = 1; k <= 54; k++) begin
        tick();
        if (count_valid) begin
          check($sformatf("tbl%0d_count", v), count, vecs[v].exp_cnt);
          check($sformatf("tbl%0d_overflow", v), overflow, 0);
          nv++;
        end
      end
      check($sformatf("tbl%0d_valid_pulses", v), nv, 3);
      enable = 1'b0;
    end

    // ---------------- stall over two terminals, then back-to-back reload ----------------
    set_pattern(P_HI, P_HI);
    enable = 1'b0; count_ready = 1'b0;
    repeat (20) tick();
    enable = 1'b1;
    repeat (18) tick();
    check("stall_first_valid",   count_valid, 1);
    check("stall_first_count",   count,       P_EXP);
    check("stall_first_overrun", overrun,     0);
    pat_on = 1'b0; i = 1'b0;
    repeat (16) tick();
    check("stall_held_valid",    count_valid, 1);
    check("stall_held_count",    count,       P_EXP);
    check("stall_overrun_set",   overrun,     1);
    repeat (6) tick();
    check("stall_overrun_sticky", overrun,    1);
    repeat (9) tick();
    count_ready = 1'b1;
    tick();
    check("b2b_valid",    count_valid, 1);
    check("b2b_count",    count,       0);
    check("b2b_overrun",  overrun,     0);
    check("b2b_overflow", overflow,    0);
    enable = 1'b0;
    tick();
    check("xfer_valid_clear", count_valid, 0);

    // ---------------- enable dropped mid-window ----------------
    set_pattern(P_HI, P_HI);
    count_ready = 1'b1; enable = 1'b0;
    repeat (20) tick();
    enable = 1'b1;
    repeat (9) tick();
    enable = 1'b0;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (count_valid) nv++;
    end
    check("drop_no_valid", nv, 0);
    enable = 1'b1;
    repeat (17) tick();
    check("reen_valid_early", count_valid, 0);
    tick();
    check("reen_valid", count_valid, 1);
    check("reen_count", count,       P_EXP);
    enable = 1'b0;
    tick();

    // ---------------- level already high at enable ----------------
    pat_on = 1'b0; i = 1'b1;
    repeat (20) tick();
    check("hi_level", level, 1);
    enable = 1'b1;
    repeat (18) tick();
    check("hi_arm_valid", count_valid, 1);
    check("hi_arm_count", count,       0);
    enable = 1'b0; i = 1'b0;
    tick();

    // ---------------- asynchronous reset mid-run with count held ----------------
    set_pattern(P_HI, P_HI);
    enable = 1'b0; count_ready = 1'b0;
    repeat (20) tick();
    enable = 1'b1;
    repeat (20) tick();
    check("pre_rst_valid", count_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",    count,       0);
    check("arst_valid",    count_valid, 0);
    check("arst_overflow", overflow,    0);
    check("arst_overrun",  overrun,     0);
    check("arst_level",    level,       0);
    count_ready = 1'b1;
    tick();
    check("arst_hold_valid", count_valid, 0);
    rst_n = 1'b1;
    // enable stays high: a restart from IDLE reports after exactly 18 cycles
    repeat (17) tick();
    check("post_rst_valid_early", count_valid, 0);
    tick();
    check("post_rst_valid", count_valid, 1);
    enable = 1'b0; pat_on = 1'b0; i = 1'b0;
    tick();

    // ---------------- saturation (COUNT_W=4, WINDOW=64) ----------------
    i_b = 1'b0; ready_b = 1'b1; enable_b = 1'b1; tog_b = 1'b1;
    nv = 0;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 40) begin
        tog_b = 1'b0;
        i_b   = 1'b0;
      end
      if (valid_b) begin
        if (nv == 0) begin
          check("sat_count",    count_b, 15);
          check("sat_overflow", ovf_b,   1);
        end else if (nv == 1) begin
          check("quiet_count",    count_b, 0);
          check("quiet_overflow", ovf_b,   0);
        end
        nv++;
      end
    end
    check("sat_valid_pulses", nv, 2);
    check("sat_overrun",      ovr_b,   0);
    check("sat_level_quiet",  level_b, 0);
    enable_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
